// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - EX-stage branch resolution bus between pipeline and branch_resolve
interface branch_resolve_if;
  logic        ex_valid;
  logic        ex_stall;
  logic [2:0]  br_type;
  logic [15:0] alu_result;
  logic        alu_z;
  logic        alu_c;
  logic        alu_v;
  logic        alu_n;
  logic        flag_we;
  logic [15:0] pc_ex;
  logic [15:0] br_offset;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic [3:0]  flags_q;

  // pipeline side: drives the EX instruction, receives redirect/flush/flags
  modport master (
    output ex_valid, ex_stall, br_type, alu_result, alu_z, alu_c, alu_v, alu_n,
           flag_we, pc_ex, br_offset,
    input  redirect_valid, redirect_pc, flush_if, flush_id, flags_q
  );

  // branch unit side
  modport slave (
    input  ex_valid, ex_stall, br_type, alu_result, alu_z, alu_c, alu_v, alu_n,
           flag_we, pc_ex, br_offset,
    output redirect_valid, redirect_pc, flush_if, flush_id, flags_q
  );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch condition/target resolution, redirect and front-end flush; optional BR_STATS_EN counters
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_resolve_if.slave    bus
`ifdef BR_STATS_EN
  ,
  output logic [15:0]        br_count,
  output logic [15:0]        br_taken_count
`endif
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic        redirect_valid_q;
  logic [15:0] redirect_pc_q;
  logic        flush_q;
  logic [3:0]  flags_r;
  logic        acc;
  logic        taken;
  logic [15:0] target;

  // only a valid, non-stalled instruction seen in IDLE is evaluated; anything in FLUSH is wrong-path
  assign acc = bus.ex_valid & ~bus.ex_stall & (state == IDLE);

  // branch condition on live ALU flags (compares come from rs-rt, C is borrow) and target select
  always_comb begin
    taken  = 1'b0;
    target = bus.pc_ex + bus.br_offset;
    case (bus.br_type)
      3'd1: taken = bus.alu_z;
      3'd2: taken = ~bus.alu_z;
      3'd3: taken = bus.alu_n ^ bus.alu_v;
      3'd4: taken = ~(bus.alu_n ^ bus.alu_v);
      3'd5: taken = bus.alu_c;
      3'd6: taken = ~bus.alu_c;
      3'd7: begin
        taken  = 1'b1;
        target = bus.alu_result;
      end
      default: taken = 1'b0;
    endcase
  end

  // redirect/flush FSM; the flush counter runs regardless of ex_stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 16'h0000;
      flush_q          <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (acc && taken) begin
            state            <= FLUSH;
            cnt              <= CNT_INIT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target;
            flush_q          <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == 3'd0) begin
            state   <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // architectural flags, written even when the same instruction is a taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (acc && bus.flag_we) begin
      flags_r <= {bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_n};
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_if       = flush_q;
  assign bus.flush_id       = flush_q;
  assign bus.flags_q        = flags_r;

`ifdef BR_STATS_EN
  // saturating counters of accepted branches and of accepted taken branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count       <= 16'h0000;
      br_taken_count <= 16'h0000;
    end else if (acc && (bus.br_type != 3'd0)) begin
      if (br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if (taken && (br_taken_count != 16'hFFFF)) br_taken_count <= br_taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  branch_resolve_if bus();

`ifdef BR_STATS_EN
  logic [15:0] br_count;
  logic [15:0] br_taken_count;
`endif

  branch_resolve #(.FLUSH_CYCLES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef BR_STATS_EN
    ,
    .br_count(br_count),
    .br_taken_count(br_taken_count)
`endif
  );

  always #5 clk = ~clk;

  // single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // present one EX instruction; f is {z,c,v,n}
  task automatic drive(input logic [2:0] t, input logic [15:0] pc, input logic [15:0] off,
                       input logic [15:0] res, input logic [3:0] f, input logic we,
                       input logic stall);
    bus.ex_valid   = 1'b1;
    bus.ex_stall   = stall;
    bus.br_type    = t;
    bus.pc_ex      = pc;
    bus.br_offset  = off;
    bus.alu_result = res;
    {bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_n} = f;
    bus.flag_we    = we;
  endtask

  task automatic idle_in();
    bus.ex_valid   = 1'b0;
    bus.ex_stall   = 1'b0;
    bus.br_type    = 3'd0;
    bus.pc_ex      = 16'h0000;
    bus.br_offset  = 16'h0000;
    bus.alu_result = 16'h0000;
    {bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_n} = 4'b0000;
    bus.flag_we    = 1'b0;
  endtask

  // instruction driven in cycle T is expected taken: redirect in T+1, flush T+1..T+2
  task automatic expect_taken(input string tag, input logic [15:0] tgt);
    @(negedge clk);
    check({tag, "_rv"}, 32'(bus.redirect_valid), 32'd1);
    check({tag, "_pc"}, 32'(bus.redirect_pc), 32'(tgt));
    check({tag, "_fl1"}, 32'({bus.flush_if, bus.flush_id}), 32'b11);
    idle_in();
    @(negedge clk);
    check({tag, "_rv2"}, 32'(bus.redirect_valid), 32'd0);
    check({tag, "_hold"}, 32'(bus.redirect_pc), 32'(tgt));
    check({tag, "_fl2"}, 32'({bus.flush_if, bus.flush_id}), 32'b11);
    @(negedge clk);
    check({tag, "_fl3"}, 32'({bus.flush_if, bus.flush_id}), 32'b00);
  endtask

  task automatic expect_not_taken(input string tag);
    @(negedge clk);
    check({tag, "_rv"}, 32'(bus.redirect_valid), 32'd0);
    check({tag, "_fl"}, 32'({bus.flush_if, bus.flush_id}), 32'b00);
    idle_in();
  endtask

  initial begin
    idle_in();
    repeat (2) @(negedge clk);
    check("rst_rv", 32'(bus.redirect_valid), 32'd0);
    check("rst_pc", 32'(bus.redirect_pc), 32'h0000);
    check("rst_fl", 32'({bus.flush_if, bus.flush_id}), 32'b00);
    check("rst_flags", 32'(bus.flags_q), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ taken with negative offset: 0x0010 + 0xFFFC = 0x000C
    drive(3'd1, 16'h0010, 16'hFFFC, 16'h0000, 4'b1000, 1'b0, 1'b0);
    expect_taken("beq", 16'h000C);

    // 0xFFFF - 0x0001: N=1 V=0 C=0 -> BLT taken, BLTU not taken
    drive(3'd3, 16'h0100, 16'h0020, 16'hFFFE, 4'b0001, 1'b0, 1'b0);
    expect_taken("blt", 16'h0120);
    drive(3'd5, 16'h0100, 16'h0020, 16'hFFFE, 4'b0001, 1'b0, 1'b0);
    expect_not_taken("bltu");

    // BNE with Z=1 is not taken; BGEU with no borrow is taken
    drive(3'd2, 16'h0300, 16'h0008, 16'h0000, 4'b1000, 1'b0, 1'b0);
    expect_not_taken("bne_nt");
    drive(3'd6, 16'h0200, 16'h0004, 16'h0001, 4'b0000, 1'b0, 1'b0);
    expect_taken("bgeu", 16'h0204);

    // JR target from ALU, and silent wrap on the branch adder
    drive(3'd7, 16'h1234, 16'h0040, 16'hFFFE, 4'b0000, 1'b0, 1'b0);
    expect_taken("jr", 16'hFFFE);
    drive(3'd1, 16'hFFFF, 16'h0002, 16'h0000, 4'b1000, 1'b0, 1'b0);
    expect_taken("wrap", 16'h0001);

    // non-branch flag write {Z,C,V,N}=1010, visible next cycle
    drive(3'd0, 16'h0400, 16'h0000, 16'h0000, 4'b1010, 1'b1, 1'b0);
    @(negedge clk);
    check("flags_wr", 32'(bus.flags_q), 32'hA);
    check("nb_rv", 32'(bus.redirect_valid), 32'd0);
    idle_in();

    // shadow squash: BNE taken at T, BEQ taken with flag_we at T+1 is dropped
    drive(3'd2, 16'h0500, 16'h0010, 16'h0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    check("sh_rv", 32'(bus.redirect_valid), 32'd1);
    check("sh_pc", 32'(bus.redirect_pc), 32'h0510);
    drive(3'd1, 16'h0600, 16'h0010, 16'h0000, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    check("sh_rv2", 32'(bus.redirect_valid), 32'd0);
    check("sh_pc2", 32'(bus.redirect_pc), 32'h0510);
    check("sh_fl2", 32'(bus.flush_if), 32'd1);
    idle_in();
    @(negedge clk);
    check("sh_rv3", 32'(bus.redirect_valid), 32'd0);
    check("sh_flags", 32'(bus.flags_q), 32'hA);
    check("sh_fl3", 32'(bus.flush_id), 32'd0);

    // stall: taken BEQ held 3 cycles, redirect one cycle after stall drops
    drive(3'd1, 16'h0700, 16'h0002, 16'h0000, 4'b1000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rv", 32'(bus.redirect_valid), 32'd0);
      check("stall_fl", 32'(bus.flush_if), 32'd0);
    end
    bus.ex_stall = 1'b0;
    expect_taken("stall", 16'h0702);

`ifdef BR_STATS_EN
    // accepted branches: beq blt bltu bne bgeu jr wrap bne-shadow stall-beq = 9, taken = 7
    check("st_cnt", 32'(br_count), 32'd9);
    check("st_taken", 32'(br_taken_count), 32'd7);
`endif

    // asynchronous reset in the middle of a flush
    drive(3'd1, 16'h0800, 16'h0004, 16'h0000, 4'b1000, 1'b0, 1'b0);
    @(negedge clk);
    idle_in();
    check("mf_fl", 32'(bus.flush_if), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mf_rv", 32'(bus.redirect_valid), 32'd0);
    check("mf_pc", 32'(bus.redirect_pc), 32'h0000);
    check("mf_fl0", 32'({bus.flush_if, bus.flush_id}), 32'b00);
    check("mf_flags", 32'(bus.flags_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(3'd1, 16'h0100, 16'h0010, 16'h0000, 4'b1000, 1'b0, 1'b0);
    expect_taken("post_rst", 16'h0110);
`ifdef BR_STATS_EN
    check("st_cnt_rst", 32'(br_count), 32'd1);
    check("st_taken_rst", 32'(br_taken_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop in case the stimulus process ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the 16-bit pipelined CPU. It consumes the ALU result and Z/C/V/N flags of the instruction in EX and evaluates the branch condition. On a taken branch it issues a one-cycle PC redirect and a multi-cycle front-end flush. It also keeps an architectural flag register updated by flag-writing instructions.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush_if`/`flush_id` stay asserted after a taken branch (legal 1..7).
- `clk` in 1: core clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: instruction in EX is valid.
- `ex_stall` in 1: EX holds this cycle; no evaluation, no flag write.
- `br_type` in 3: 0 none, 1 BEQ, 2 BNE, 3 BLT (signed), 4 BGE (signed), 5 BLTU, 6 BGEU, 7 JR.
- `alu_result` in 16: ALU result (JR target; rs−rt for compares).
- `alu_z`, `alu_c`, `alu_v`, `alu_n` in 1 each: live ALU flags.
- `flag_we` in 1: instruction updates the flag register.
- `pc_ex` in 16: PC of the instruction in EX.
- `br_offset` in 16: sign-extended branch offset, in words.
- `redirect_valid` out 1: one-cycle redirect strobe.
- `redirect_pc` out 16: redirect target.
- `flush_if`, `flush_id` out 1: squash the IF and ID stages.
- `flags_q` out 4: registered {Z,C,V,N}.

## Operation
- Accept condition: `acc = ex_valid & ~ex_stall & (state==IDLE)`. Inputs are ignored when `acc` is 0.
- Condition, evaluated on live flags; compares use an ALU SUB:
  - BEQ: Z
  - BNE: ~Z
  - BLT: N^V
  - BGE: ~(N^V)
  - BLTU: C (borrow)
  - BGEU: ~C
  - JR: always taken
  - none: never taken
- Target: `pc_ex + br_offset` mod 2^16 for conditional branches; `alu_result` for JR. No carry-out; wrap-around is silent (0xFFFF + 2 = 0x0001).
- Flag register: when `acc & flag_we`, `flags_q <= {alu_z,alu_c,alu_v,alu_n}`. The write happens even if the same instruction is a taken branch.
- FSM:
  - IDLE: taken & `acc` -> FLUSH, counter loaded with FLUSH_CYCLES−1, redirect registered.
  - FLUSH: counter decrements each cycle regardless of `ex_stall`. At 0 -> IDLE.
- Every EX instruction arriving while in FLUSH is a wrong-path squash. It does not evaluate and does not write flags.

## Timing
- Latency: taken branch accepted in cycle T.
  - `redirect_valid`=1 and `redirect_pc` valid in T+1 only.
  - `flush_if`/`flush_id`=1 in T+1 .. T+FLUSH_CYCLES.
  - FSM is back in IDLE and able to accept in T+FLUSH_CYCLES+1.
- `redirect_pc` holds its last value when `redirect_valid`=0.
- `flags_q` is visible the cycle after the write.
- Back-to-back branches: a second taken branch in T+1..T+FLUSH_CYCLES is squashed and produces no redirect.
- Reset values: `redirect_valid`=0, `redirect_pc`=0x0000, `flush_if`=`flush_id`=0, `flags_q`=4'b0000, state IDLE, counter 0.
- Reset asserted mid-flush forces all outputs to their reset values immediately, without waiting for a clock edge. After release the block is in IDLE.
- `ex_stall`=1 with a taken branch present: no redirect until the cycle `ex_stall` drops.

## Configuration
- `BR_STATS_EN` defined: adds outputs `br_count` (16) and `br_taken_count` (16), both reset to 0.
  - `br_count` increments on every accepted `br_type`≠0.
  - `br_taken_count` increments on every accepted taken branch.
  - Both saturate at 0xFFFF.
- `BR_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 mid-FLUSH with FLUSH_CYCLES=2 -> all outputs 0 immediately. First accepted branch after release is evaluated normally.
- BEQ taken: `pc_ex`=0x0010, `br_offset`=0xFFFC, `alu_z`=1 -> T+1 `redirect_valid`=1, `redirect_pc`=0x000C. Flush high for exactly 2 cycles.
- Signed vs unsigned: a=0xFFFF, b=0x0001 SUB (N=1,V=0,C=0):
  - BLT -> taken.
  - BLTU -> not taken, no flush.
- JR with wrap: `alu_result`=0xFFFE -> `redirect_pc`=0xFFFE. BEQ with `pc_ex`=0xFFFF, `br_offset`=0x0002, Z=1 -> `redirect_pc`=0x0001.
- Shadow squash: taken BNE at T, then taken BEQ with `flag_we`=1 at T+1 -> single redirect only, `flags_q` unchanged.
- Stall: taken BEQ with `ex_stall`=1 for 3 cycles -> no redirect. Redirect appears one cycle after the stall drops. With `BR_STATS_EN`, `br_taken_count` increments exactly once.
